// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V pipeline: ALU operation codes and
// hazard-unit forwarding selects.
package riscv_pkg;

    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned FWD_W    = 2;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b101;

    // 2'b11 is reserved and behaves like FWD_REG.
    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU for the execute stage: add/sub/and/or/slt with
// a zero flag used for beq resolution.
module alu
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]     SrcA,
    input  logic [XLEN-1:0]     SrcB,
    input  logic [ALU_OP_W-1:0] ALUControl,
    output logic [XLEN-1:0]     Result,
    output logic                Zero
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            less_signed;

    assign sum         = SrcA + SrcB;
    assign diff        = SrcA - SrcB;
    assign less_signed = $signed(SrcA) < $signed(SrcB);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = sum;
            ALU_SUB: Result = diff;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, less_signed};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch target/decision and the
// EX/MEM pipeline register.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RegWriteE,
    input  logic                ALUSrcE,
    input  logic                MemWriteE,
    input  logic                ResultSrcE,
    input  logic                BranchE,
    input  logic [ALU_OP_W-1:0] ALUControlE,
    input  logic [XLEN-1:0]     RD1_E,
    input  logic [XLEN-1:0]     RD2_E,
    input  logic [XLEN-1:0]     Imm_Ext_E,
    input  logic [4:0]          RD_E,
    input  logic [XLEN-1:0]     PCE,
    input  logic [XLEN-1:0]     PCPlus4E,
    input  logic [FWD_W-1:0]    ForwardA_E,
    input  logic [FWD_W-1:0]    ForwardB_E,
    input  logic [XLEN-1:0]     ResultW,
    output logic                PCSrcE,
    output logic [XLEN-1:0]     PCTargetE,
    output logic                RegWriteM,
    output logic                MemWriteM,
    output logic                ResultSrcM,
    output logic [4:0]          RD_M,
    output logic [XLEN-1:0]     ALUResultM,
    output logic [XLEN-1:0]     WriteDataM,
    output logic [XLEN-1:0]     PCPlus4M
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    // FWD_MEM picks up the previous instruction's registered result.
    always_comb begin
        src_a = RD1_E;
        case (ForwardA_E)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        src_b_fwd = RD2_E;
        case (ForwardB_E)
            FWD_WB:  src_b_fwd = ResultW;
            FWD_MEM: src_b_fwd = ALUResultM;
            default: src_b_fwd = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .SrcA      (src_a),
        .SrcB      (src_b),
        .ALUControl(ALUControlE),
        .Result    (alu_result),
        .Zero      (alu_zero)
    );

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = ~rst & BranchE & alu_zero;

    // Store data is the forwarded operand, not raw RD2_E.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= alu_result;
            WriteDataM <= src_b_fwd;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed, table-driven bench for execute_cycle plus hand-written
// reset and forwarding sequences.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E;
    logic [4:0]  RD_E;
    logic [31:0] PCE, PCPlus4E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int checks = 0;
    int errors = 0;

    execute_cycle #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteE  (RegWriteE),
        .ALUSrcE    (ALUSrcE),
        .MemWriteE  (MemWriteE),
        .ResultSrcE (ResultSrcE),
        .BranchE    (BranchE),
        .ALUControlE(ALUControlE),
        .RD1_E      (RD1_E),
        .RD2_E      (RD2_E),
        .Imm_Ext_E  (Imm_Ext_E),
        .RD_E       (RD_E),
        .PCE        (PCE),
        .PCPlus4E   (PCPlus4E),
        .ForwardA_E (ForwardA_E),
        .ForwardB_E (ForwardB_E),
        .ResultW    (ResultW),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RD_M       (RD_M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  alu_ctl;
        logic        alu_src;
        logic        branch;
        logic        mem_write;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pce;
        logic [31:0] exp_alu;
        logic [31:0] exp_wd;
        logic        exp_pcsrc;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
        ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
        PCE = 0; PCPlus4E = 0; ForwardA_E = 2'b00; ForwardB_E = 2'b00; ResultW = 0;
    endtask

    function automatic vec_t mk(input logic [2:0] c, input logic s, input logic b,
                                input logic mw, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] ea, input logic [31:0] ew,
                                input logic ep, input logic [31:0] et);
        vec_t v;
        v.alu_ctl = c; v.alu_src = s; v.branch = b; v.mem_write = mw;
        v.rd1 = a; v.rd2 = d; v.imm = i; v.pce = p;
        v.exp_alu = ea; v.exp_wd = ew; v.exp_pcsrc = ep; v.exp_target = et;
        return v;
    endfunction

    initial begin
        //            ctl     src b  mw rd1           rd2           imm           pce
        vecs[0]  = mk(3'b000, 0, 0, 0, 32'd7,        32'd5,        32'd0,        32'd0,
                      32'd12,       32'd5,        0, 32'd0);
        vecs[1]  = mk(3'b001, 0, 0, 0, 32'd7,        32'd5,        32'd0,        32'd0,
                      32'd2,        32'd5,        0, 32'd0);
        vecs[2]  = mk(3'b010, 0, 0, 0, 32'd7,        32'd5,        32'd0,        32'd0,
                      32'd5,        32'd5,        0, 32'd0);
        vecs[3]  = mk(3'b011, 0, 0, 0, 32'd7,        32'd5,        32'd0,        32'd0,
                      32'd7,        32'd5,        0, 32'd0);
        vecs[4]  = mk(3'b101, 0, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,
                      32'd1,        32'd1,        0, 32'd0);
        vecs[5]  = mk(3'b101, 0, 0, 0, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,
                      32'd0,        32'hFFFFFFFF, 0, 32'd0);
        vecs[6]  = mk(3'b000, 1, 0, 1, 32'h100,      32'hAB,       32'h10,       32'd0,
                      32'h110,      32'hAB,       0, 32'h10);
        vecs[7]  = mk(3'b001, 0, 1, 0, 32'h20,       32'h20,       32'hFFFFFFF8, 32'h40,
                      32'd0,        32'h20,       1, 32'h38);
        vecs[8]  = mk(3'b001, 0, 1, 0, 32'h20,       32'h21,       32'hFFFFFFF8, 32'h40,
                      32'hFFFFFFFF, 32'h21,       0, 32'h38);
        vecs[9]  = mk(3'b000, 0, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,
                      32'd0,        32'd1,        0, 32'd0);
        vecs[10] = mk(3'b000, 0, 1, 0, 32'd0,        32'd0,        32'd8,        32'hFFFFFFFC,
                      32'd0,        32'd0,        1, 32'h4);
        vecs[11] = mk(3'b110, 0, 1, 0, 32'd7,        32'd5,        32'd0,        32'd0,
                      32'd0,        32'd5,        1, 32'd0);
        vecs[12] = mk(3'b111, 0, 0, 1, 32'd7,        32'd5,        32'd3,        32'd0,
                      32'd0,        32'd5,        0, 32'd3);

        // Reset with nonzero inputs; branch condition true but must be masked.
        drive_idle();
        rst = 1; RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; BranchE = 1;
        ALUControlE = 3'b001; RD1_E = 32'h20; RD2_E = 32'h20; RD_E = 5'd5;
        PCE = 32'h40; PCPlus4E = 32'h44;
        #1 chk("rst_pcsrc", {31'd0, PCSrcE}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_regwrite", {31'd0, RegWriteM}, 32'd0);
        chk("rst_memwrite", {31'd0, MemWriteM}, 32'd0);
        chk("rst_resultsrc", {31'd0, ResultSrcM}, 32'd0);
        chk("rst_rd", {27'd0, RD_M}, 32'd0);
        chk("rst_alu", ALUResultM, 32'd0);
        chk("rst_wd", WriteDataM, 32'd0);
        chk("rst_pc4", PCPlus4M, 32'd0);
        chk("rst_pcsrc2", {31'd0, PCSrcE}, 32'd0);
        @(negedge clk); rst = 0;
        #1 chk("rel_pcsrc", {31'd0, PCSrcE}, 32'd1);
        @(posedge clk); #1;
        chk("rel_regwrite", {31'd0, RegWriteM}, 32'd1);
        chk("rel_memwrite", {31'd0, MemWriteM}, 32'd1);
        chk("rel_resultsrc", {31'd0, ResultSrcM}, 32'd1);
        chk("rel_rd", {27'd0, RD_M}, 32'd5);
        chk("rel_wd", WriteDataM, 32'h20);
        chk("rel_pc4", PCPlus4M, 32'h44);

        // Table of single-cycle vectors, no forwarding.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive_idle();
            ALUControlE = vecs[i].alu_ctl; ALUSrcE = vecs[i].alu_src;
            BranchE = vecs[i].branch; MemWriteE = vecs[i].mem_write;
            RD1_E = vecs[i].rd1; RD2_E = vecs[i].rd2; Imm_Ext_E = vecs[i].imm;
            PCE = vecs[i].pce; PCPlus4E = vecs[i].pce + 32'd4;
            RD_E = 5'(i + 1); RegWriteE = i[0]; ResultSrcE = i[1];
            #1;
            chk($sformatf("v%0d_pcsrc", i), {31'd0, PCSrcE}, {31'd0, vecs[i].exp_pcsrc});
            chk($sformatf("v%0d_target", i), PCTargetE, vecs[i].exp_target);
            @(posedge clk); #1;
            chk($sformatf("v%0d_alu", i), ALUResultM, vecs[i].exp_alu);
            chk($sformatf("v%0d_wd", i), WriteDataM, vecs[i].exp_wd);
            chk($sformatf("v%0d_memwrite", i), {31'd0, MemWriteM}, {31'd0, vecs[i].mem_write});
            chk($sformatf("v%0d_regwrite", i), {31'd0, RegWriteM}, {31'd0, i[0]});
            chk($sformatf("v%0d_resultsrc", i), {31'd0, ResultSrcM}, {31'd0, i[1]});
            chk($sformatf("v%0d_rd", i), {27'd0, RD_M}, 32'(i + 1));
            chk($sformatf("v%0d_pc4", i), PCPlus4M, vecs[i].pce + 32'd4);
        end

        // Back-to-back dependency: 3+4, then MEM and WB forwards together.
        @(negedge clk); drive_idle();
        RD1_E = 32'd3; RD2_E = 32'd4;
        @(posedge clk); #1 chk("fwd_base", ALUResultM, 32'd7);
        @(negedge clk); drive_idle();
        ForwardA_E = 2'b10; ForwardB_E = 2'b01; ResultW = 32'd9; MemWriteE = 1;
        @(posedge clk); #1;
        chk("fwd_alu", ALUResultM, 32'd16);
        chk("fwd_wd", WriteDataM, 32'd9);
        chk("fwd_memwrite", {31'd0, MemWriteM}, 32'd1);
        // Reserved select 11 reads the register file operand.
        @(negedge clk); drive_idle();
        ForwardA_E = 2'b11; RD1_E = 32'd2; RD2_E = 32'd3; ResultW = 32'd50;
        @(posedge clk); #1 chk("fwd_rsvd", ALUResultM, 32'd5);
        // WB forward on A with immediate; MEM forward still reaches store data.
        @(negedge clk); drive_idle();
        ForwardA_E = 2'b01; ForwardB_E = 2'b10; ResultW = 32'd100;
        ALUSrcE = 1; Imm_Ext_E = 32'd1; RD2_E = 32'hDEAD;
        @(posedge clk); #1;
        chk("fwd_wb_a", ALUResultM, 32'd101);
        chk("fwd_mem_wd", WriteDataM, 32'd5);
        // Forwarded zero result drives the branch decision.
        @(negedge clk); drive_idle();
        ForwardA_E = 2'b10; ALUControlE = 3'b001; RD2_E = 32'd101; BranchE = 1;
        #1 chk("fwd_branch", {31'd0, PCSrcE}, 32'd1);

        // Mid-stream reset clears state and forwarding source.
        @(negedge clk); drive_idle(); rst = 1; RD1_E = 32'd9;
        @(posedge clk); #1 chk("rst2_alu", ALUResultM, 32'd0);
        @(negedge clk); rst = 0; drive_idle(); ForwardA_E = 2'b10; RD2_E = 32'd1;
        @(posedge clk); #1 chk("rst2_fwd", ALUResultM, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the five-stage RISC-V pipeline: consumes the ID/EX signals produced by `decode_cycle`, applies EX-stage operand forwarding, computes the ALU result and the branch target/decision, and registers the results into the EX/MEM pipeline register that feeds `memory_cycle`. Branch resolution (`PCSrcE`, `PCTargetE`) is returned combinationally to `fetch_cycle`.

## Interface
- `XLEN`, 32, datapath width
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE`  in  1 each  control bits from ID/EX
- `ALUControlE`  in  3  ALU operation
- `RD1_E, RD2_E, Imm_Ext_E`  in  XLEN  register operands, sign-extended immediate
- `RD_E`  in  5  destination register index
- `PCE, PCPlus4E`  in  XLEN  instruction PC, PC+4
- `ForwardA_E, ForwardB_E`  in  2  forwarding selects from hazard unit
- `ResultW`  in  XLEN  writeback-stage result (forward source)
- `PCSrcE`  out  1  branch taken (combinational)
- `PCTargetE`  out  XLEN  PCE + Imm_Ext_E (combinational)
- `RegWriteM, MemWriteM, ResultSrcM`  out  1 each  registered control
- `RD_M`  out  5  registered destination index
- `ALUResultM, WriteDataM, PCPlus4M`  out  XLEN  registered datapath

## Operation
- Forward mux A: 00 → RD1_E, 01 → ResultW, 10 → ALUResultM (own registered output), 11 → RD1_E (reserved, treated as 00).
- Forward mux B: same encoding on RD2_E; result is `SrcBFwd`.
- SrcA = mux A; SrcB = ALUSrcE ? Imm_Ext_E : SrcBFwd.
- ALUControlE: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed, result 0/1 zero-extended); 100/110/111 → result 0.
- Add/sub wrap modulo 2^XLEN; no overflow flag.
- Zero = (ALU result == 0). PCSrcE = BranchE & Zero (beq only). PCTargetE = PCE + Imm_Ext_E, wraps.
- EX/MEM register on every rising edge: RegWriteM←RegWriteE, MemWriteM←MemWriteE, ResultSrcM←ResultSrcE, RD_M←RD_E, ALUResultM←ALU result, WriteDataM←SrcBFwd (forwarded, not raw RD2_E), PCPlus4M←PCPlus4E.
- No stall/enable: register loads every cycle; bubbles arrive as zeroed controls from decode.

## Timing
- Latency: EX inputs → M outputs, 1 cycle. PCSrcE/PCTargetE: 0 cycles.
- Reset (rst=1 at edge): all M outputs → 0. While rst=1, PCSrcE forced 0; PCTargetE unconstrained.
- Reset deasserted mid-stream: first valid M outputs appear on the edge after the first non-reset edge with valid EX inputs; no state survives reset.
- ForwardA_E=10 uses the ALUResultM value present before the current edge (back-to-back dependency), i.e. previous instruction's result.
- Simultaneous ForwardA_E=10 and ForwardB_E=01 are independent; each mux resolves separately.
- ResultW and forward selects must be stable before the rising edge; no internal bypass of ResultW beyond the mux.

## Structure
- Shared package `riscv_pkg`: ALU op constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), forward-select constants (FWD_REG, FWD_WB, FWD_MEM).
- One sub-module: `alu` (combinational; inputs SrcA, SrcB, ALUControl; outputs Result, Zero). Forward muxes, target adder and EX/MEM register live in `execute_cycle`.

## Test plan
- Reset: hold rst=1 for 2 edges with nonzero inputs → all M outputs 0, PCSrcE=0; release → next edge loads inputs.
- ALU ops, no forwarding: RD1_E=7, RD2_E=5, ALUSrcE=0: 000→ALUResultM=12; 001→2; 010→5; 011→7; 101 with RD1_E=0xFFFFFFFF (−1), RD2_E=1 → 1.
- Immediate + store data: ALUSrcE=1, RD1_E=0x100, Imm_Ext_E=0x10, RD2_E=0xAB, MemWriteE=1 → ALUResultM=0x110, WriteDataM=0xAB, MemWriteM=1 one cycle later.
- Forwarding: cycle 1 add 3+4 (ALUResultM=7); cycle 2 ForwardA_E=10, ForwardB_E=01, ResultW=9, RD1_E/RD2_E=0, add → ALUResultM=16; ForwardB_E=01 with store → WriteDataM=9.
- Branch: BranchE=1, sub, RD1_E=RD2_E=0x20, PCE=0x40, Imm_Ext_E=0xFFFFFFF8 → PCSrcE=1, PCTargetE=0x38 same cycle; RD2_E=0x21 → PCSrcE=0.
- Wrap: add 0xFFFFFFFF+1 → ALUResultM=0; PCE=0xFFFFFFFC, Imm=8 → PCTargetE=0x4; unused ALUControlE=110 → ALUResultM=0.
